// File: rtl/if_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage:
//   - PC_RESET_DEFAULT : first fetch address after reset
//   - FS_TO_DS_BUS_WD  : width of the fetch->decode bus, laid out {adef, pc, inst}
//   - fs_state_e       : fetch control states
//   - pack_fs_bus()    : builds one fetch->decode bus word
// ----------------------------------------------------------------------------
package if_stage_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h1c00_0000;

   // Fetch->decode bus layout: {adef[64], pc[63:32], inst[31:0]}
   localparam int FS_TO_DS_BUS_WD = 65;
   localparam int BUS_INST_LSB    = 0;
   localparam int BUS_PC_LSB      = 32;
   localparam int BUS_ADEF_BIT    = 64;

   typedef enum logic [1:0] {
      FS_FETCH    = 2'd0,
      FS_STALL    = 2'd1,
      FS_REDIRECT = 2'd2
   } fs_state_e;

   function automatic logic [FS_TO_DS_BUS_WD-1:0] pack_fs_bus(
      input logic        adef,
      input logic [31:0] pc,
      input logic [31:0] inst
   );
      return {adef, pc, inst};
   endfunction

endpackage

// File: rtl/if_stage_inst_fifo.sv
// ----------------------------------------------------------------------------
// if_stage_inst_fifo
// DEPTH x WIDTH instruction buffer between the SRAM return path and decode.
// Flush has priority over push and pop. Head is read combinationally from
// the storage array so decode sees the oldest entry without extra latency.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, push_data     write one entry at the tail
//   pop                 retire the head entry
//   flush               drop every entry (wins over push/pop)
//   count               number of valid entries (0..DEPTH)
//   head                oldest entry (meaningless when count==0)
// ----------------------------------------------------------------------------
module if_stage_inst_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 65
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop  && !flush && (count_reg != '0);
   // A push into a full buffer is only legal when the head leaves in the same cycle.
   assign do_push = push && !flush && ((count_reg != DEPTH_C) || do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by count_reg alone.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   assign count = count_reg;
   assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: issues sequential PCs to a one-cycle-latency
// instruction SRAM, buffers returned words in a small FIFO and hands
// {pc, inst, adef} to decode over a valid/allow-in handshake. A one-cycle
// br_taken pulse flushes buffered and in-flight fetches and redirects.
// Optional feature macro: IF_ADDR_ALIGN_CHECK_EN
//   defined   : a misaligned br_target produces one adef entry, then issue
//               stays blocked until the next redirect or reset
//   undefined : br_target[1:0] is forced to 0, fs_to_ds_excp_adef is 0
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   inst_sram_en/we/addr/wdata/rdata   instruction SRAM (read-only use)
//   br_taken, br_target                redirect pulse and target from decode
//   ds_allow_in                        decode accepts the head this cycle
//   fs_to_ds_valid/pc/inst/excp_adef   buffer head towards decode
// ----------------------------------------------------------------------------
module if_stage
   import if_stage_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        inst_sram_en,
   output logic        inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        ds_allow_in,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_to_ds_pc,
   output logic [31:0] fs_to_ds_inst,
   output logic        fs_to_ds_excp_adef
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [31:0]  fetch_pc_reg;
   logic         inflight_reg;
   logic [31:0]  inflight_pc_reg;
   logic         discard_reg;
   fs_state_e    state_reg;
   fs_state_e    state_next;

   logic [CW-1:0]              fifo_count;
   logic [FS_TO_DS_BUS_WD-1:0] fifo_head;
   logic [FS_TO_DS_BUS_WD-1:0] fifo_push_data;
   logic                       fifo_push;
   logic                       pop;
   logic [CW:0]                occupancy;
   logic                       issue;
   logic                       issue_block;
   logic [31:0]                br_target_eff;
   logic                       adef_en;

   // Handshake depends only on registered FIFO state, never on inst_sram_rdata.
   assign fs_to_ds_valid = (fifo_count != '0);
   assign pop            = fs_to_ds_valid && ds_allow_in;

   // Entries already buffered plus the one returning this cycle, minus the
   // one leaving: a new request is allowed only if its return will fit.
   assign occupancy = {1'b0, fifo_count}
                    + {{CW{1'b0}}, inflight_reg}
                    - {{CW{1'b0}}, pop};

`ifdef IF_ADDR_ALIGN_CHECK_EN
   logic adef_pend_reg;   // push the fault entry next cycle
   logic adef_lock_reg;   // hold off issue after a faulting redirect
   logic br_misalign;

   assign br_misalign   = |br_target[1:0];
   assign br_target_eff = br_target;
   assign issue_block   = adef_lock_reg;
   assign adef_en       = 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adef_pend_reg <= 1'b0;
         adef_lock_reg <= 1'b0;
      end else if (br_taken) begin
         adef_pend_reg <= br_misalign;
         adef_lock_reg <= br_misalign;
      end else begin
         adef_pend_reg <= 1'b0;
      end
   end

   // fetch_pc_reg already holds the faulting target in the cycle after the redirect.
   assign fifo_push      = adef_pend_reg || (inflight_reg && !discard_reg);
   assign fifo_push_data = adef_pend_reg ? pack_fs_bus(1'b1, fetch_pc_reg, 32'h0)
                                         : pack_fs_bus(1'b0, inflight_pc_reg, inst_sram_rdata);
`else
   assign br_target_eff  = br_target & 32'hffff_fffc;
   assign issue_block    = 1'b0;
   assign adef_en        = 1'b0;
   assign fifo_push      = inflight_reg && !discard_reg;
   assign fifo_push_data = pack_fs_bus(1'b0, inflight_pc_reg, inst_sram_rdata);
`endif

   // reset gates issue so the SRAM sees no request while reset is held.
   assign issue = !reset && !br_taken && !issue_block && (occupancy < DEPTH_C);

   assign inst_sram_en    = issue;
   assign inst_sram_we    = 1'b0;
   assign inst_sram_addr  = fetch_pc_reg;
   assign inst_sram_wdata = 32'h0;

   if_stage_inst_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FS_TO_DS_BUS_WD)
   ) u_inst_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (pop),
      .flush     (br_taken),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   // Head fields are masked when empty so decode sees zeros, not stale storage.
   assign fs_to_ds_pc        = fs_to_ds_valid ? fifo_head[BUS_PC_LSB +: 32]   : 32'h0;
   assign fs_to_ds_inst      = fs_to_ds_valid ? fifo_head[BUS_INST_LSB +: 32] : 32'h0;
   assign fs_to_ds_excp_adef = fs_to_ds_valid && adef_en && fifo_head[BUS_ADEF_BIT];

   // Control state: tracks whether fetch is running, back-pressured or redirecting.
   always_comb begin
      state_next = state_reg;
      if (br_taken) begin
         state_next = FS_REDIRECT;
      end else begin
         case (state_reg)
            FS_FETCH:    if (!issue) state_next = FS_STALL;
            FS_STALL:    if (pop)    state_next = FS_FETCH;
            FS_REDIRECT:             state_next = FS_FETCH;
            default:                 state_next = FS_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= FS_FETCH;
         fetch_pc_reg    <= PC_RESET;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= 32'h0;
         discard_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         inflight_reg <= issue;
         // A word still returning when the redirect arrives must not reach decode.
         discard_reg  <= br_taken && inflight_reg;
         if (br_taken) begin
            fetch_pc_reg <= br_target_eff;
         end else if (issue) begin
            fetch_pc_reg    <= fetch_pc_reg + 32'd4;
            inflight_pc_reg <= fetch_pc_reg;
         end
      end
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the multicycle/pipelined LoongArch CPU, sitting directly upstream of the decode stage. It generates sequential PCs, drives the instruction SRAM, which has a one-cycle synchronous read latency, and buffers returned words in a small FIFO. It hands PC/instruction pairs to decode over a valid/allow-in handshake. A one-cycle redirect from decode (taken branch/jump) flushes all buffered and in-flight fetches.

## Interface
- DEPTH, 2, instruction buffer entries (≥2; power of two).
- PC_RESET, 32'h1c00_0000, first fetch address after reset.

- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- inst_sram_en  out  1  read request this cycle.
- inst_sram_we  out  1  constant 0.
- inst_sram_addr  out  32  request address; equals current fetch PC.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_rdata  in  32  data for the request issued in the previous cycle.
- br_taken  in  1  redirect pulse from decode.
- br_target  in  32  redirect address, sampled when br_taken=1.
- ds_allow_in  in  1  decode accepts an entry this cycle.
- fs_to_ds_valid  out  1  buffer head valid.
- fs_to_ds_pc  out  32  PC of head entry.
- fs_to_ds_inst  out  32  instruction of head entry.
- fs_to_ds_excp_adef  out  1  head entry has a fetch-address fault.

## Operation
- Registers: fetch_pc, FIFO (count, rd/wr pointers), inflight, inflight_pc, discard.
- Issue condition: `!br_taken && (count + inflight − pop) < DEPTH`, where `pop = fs_to_ds_valid && ds_allow_in`.
- On issue:
  - inst_sram_en=1, inst_sram_addr=fetch_pc.
  - fetch_pc += 4, wrapping mod 2^32.
  - inflight<=1, inflight_pc<=fetch_pc.
- No issue → inflight<=0.
- Return: in the cycle after an issue, if discard=0, push {inflight_pc, inst_sram_rdata} into the FIFO. The issue condition guarantees the FIFO is never overflowed.
- Pop: on pop, advance the head. A push and a pop in the same cycle leave count unchanged.
- Redirect (br_taken=1):
  - Clear the FIFO (count=0).
  - discard<=inflight, so the returning word is dropped.
  - fetch_pc<=br_target.
  - No request that cycle.
  - Any pop that cycle is ignored; redirect wins over push and pop.
- Control states:
  - FETCH: normal operation.
  - STALL: FIFO plus in-flight full, no request.
  - REDIRECT: the one cycle of br_taken.
  - Transitions: STALL→FETCH on pop. Any state→REDIRECT on br_taken. REDIRECT→FETCH next cycle.
- Outputs: fs_to_ds_* are taken from the FIFO head only; there is no bypass from inst_sram_rdata.
- Reset (asynchronous, any time):
  - fetch_pc=PC_RESET.
  - count=0, inflight=0, discard=0.
  - fs_to_ds_valid=0, fs_to_ds_pc=0, fs_to_ds_inst=0, fs_to_ds_excp_adef=0, inst_sram_en=0.

## Timing
- After reset deassertion, cycle 0 issues PC_RESET; data in cycle 1; fs_to_ds_valid=1 in cycle 2.
- Steady state: one instruction per cycle while ds_allow_in=1.
- Redirect in cycle T:
  - Request to br_target in T+1.
  - Valid to decode in T+3.
  - Entries visible in T are gone in T+1.
- ds_allow_in held low: at most DEPTH entries buffered and no further requests, i.e. inst_sram_en=0 while full.
- The handshake is not combinationally dependent on inst_sram_rdata.

## Configuration
- IF_ADDR_ALIGN_CHECK_EN defined:
  - A redirect to a target with br_target[1:0]≠0 issues no SRAM request.
  - Instead it pushes one entry {br_target, 32'h0} with excp_adef=1, then stalls issue until the next redirect or reset.
- Undefined:
  - br_target[1:0] is forced to 2'b00.
  - fs_to_ds_excp_adef is tied 0.

## Structure
- Shared header mycpu_defs.vh holds:
  - PC_RESET.
  - FS_TO_DS_BUS_WD (65) and the bit layout of the fetch→decode bus: {adef, pc, inst}.
- Sub-module inst_fifo:
  - Parameterised DEPTH×65-bit FIFO with push, pop, flush, count, head outputs.
  - Flush has priority over push and pop.

## Test plan
- Reset release, ds_allow_in=1, SRAM returns addr as data → fs_to_ds_pc 1c000000, 1c000004, 1c000008 on consecutive cycles starting cycle 2, with inst equal to pc.
- ds_allow_in=0 for 6 cycles → exactly DEPTH entries held, inst_sram_en=0 after the FIFO fills, order preserved on release.
- br_taken with br_target=1c000100 while full and one fetch in flight → no stale PC ever valid; first valid PC is 1c000100 at T+3.
- br_taken coincident with pop and return → pop ignored, returned word dropped, FIFO empty at T+1.
- Reset asserted mid-stream → all outputs 0 immediately (asynchronous); after release, fetch restarts at 1c000000.
- IF_ADDR_ALIGN_CHECK_EN defined, br_target=1c000102 → single entry, pc=1c000102, inst=0, adef=1, no SRAM request. Undefined → first request to 1c000100.
